// File: rtl/riscv_core_pkg.sv
// Shared RV32 decode constants and types for the ID and EX stages.
package riscv_core_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam int FUNCT_W = 10;
  localparam logic [FUNCT_W-1:0] FUNCT_NOP     = 10'd0;
  localparam logic [FUNCT_W-1:0] FUNCT_ADD_OH  = 10'b00_0000_0001;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB_OH  = 10'b00_0000_0010;
  localparam logic [FUNCT_W-1:0] FUNCT_OR_OH   = 10'b00_0000_0100;
  localparam logic [FUNCT_W-1:0] FUNCT_XOR_OH  = 10'b00_0000_1000;
  localparam logic [FUNCT_W-1:0] FUNCT_AND_OH  = 10'b00_0001_0000;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT_OH  = 10'b00_0010_0000;
  localparam logic [FUNCT_W-1:0] FUNCT_SLTU_OH = 10'b00_0100_0000;
  localparam logic [FUNCT_W-1:0] FUNCT_SLL_OH  = 10'b00_1000_0000;
  localparam logic [FUNCT_W-1:0] FUNCT_SRL_OH  = 10'b01_0000_0000;
  localparam logic [FUNCT_W-1:0] FUNCT_SRA_OH  = 10'b10_0000_0000;

  // Decoded op as it is carried in the ID/EX register.
  typedef struct packed {
    logic [FUNCT_W-1:0] funct;
    logic               mux1;
    logic               mux2;
    logic [31:0]        immed;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [4:0]         rd;
    logic               illegal;
  } id_dec_t;

  // funct3 -> ALU op for the funct7=0 encodings (ADD/SRL variants).
  function automatic logic [FUNCT_W-1:0] f3_base_oh(input logic [2:0] f3);
    case (f3)
      F3_ADD_SUB: f3_base_oh = FUNCT_ADD_OH;
      F3_SLL:     f3_base_oh = FUNCT_SLL_OH;
      F3_SLT:     f3_base_oh = FUNCT_SLT_OH;
      F3_SLTU:    f3_base_oh = FUNCT_SLTU_OH;
      F3_XOR:     f3_base_oh = FUNCT_XOR_OH;
      F3_SRL_SRA: f3_base_oh = FUNCT_SRL_OH;
      F3_OR:      f3_base_oh = FUNCT_OR_OH;
      default:    f3_base_oh = FUNCT_AND_OH;
    endcase
  endfunction

endpackage

// File: rtl/riscv_core_id_dec.sv
// Combinational RV32 decode of the OP/OP-IMM/LUI/AUIPC subset.
module riscv_core_id_dec
  import riscv_core_pkg::*;
(
  input  logic [31:0] instr,
  output id_dec_t     dec
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  // Field extraction plus per-opcode ALU op / operand select; illegal squashes funct and rd.
  always_comb begin
    dec         = '0;
    dec.rs1     = instr[19:15];
    dec.rs2     = instr[24:20];
    dec.rd      = instr[11:7];
    dec.illegal = 1'b0;
    case (opc)
      OPC_OP: begin
        if (f7 == F7_BASE)
          dec.funct = f3_base_oh(f3);
        else if (f7 == F7_ALT && f3 == F3_ADD_SUB)
          dec.funct = FUNCT_SUB_OH;
        else if (f7 == F7_ALT && f3 == F3_SRL_SRA)
          dec.funct = FUNCT_SRA_OH;
        else
          dec.illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.mux2 = 1'b1;
        if (f3 == F3_SLL || f3 == F3_SRL_SRA) begin
          // Shift amount is unsigned; funct7 selects logical vs arithmetic.
          dec.immed = {27'd0, instr[24:20]};
          if (f7 == F7_BASE)
            dec.funct = f3_base_oh(f3);
          else if (f7 == F7_ALT && f3 == F3_SRL_SRA)
            dec.funct = FUNCT_SRA_OH;
          else
            dec.illegal = 1'b1;
        end else begin
          dec.immed = {{20{instr[31]}}, instr[31:20]};
          dec.funct = f3_base_oh(f3);
        end
      end
      OPC_LUI: begin
        // LUI computes x0 + imm, so rs1 is pinned to x0.
        dec.funct = FUNCT_ADD_OH;
        dec.mux2  = 1'b1;
        dec.rs1   = 5'd0;
        dec.immed = {instr[31:12], 12'd0};
      end
      OPC_AUIPC: begin
        dec.funct = FUNCT_ADD_OH;
        dec.mux1  = 1'b1;
        dec.mux2  = 1'b1;
        dec.immed = {instr[31:12], 12'd0};
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.illegal) begin
      dec.funct = FUNCT_NOP;
      dec.rd    = 5'd0;
    end
  end

endmodule

// File: rtl/riscv_core_id.sv
// ID stage: fetch handshake, stall/flush control and the ID/EX output register.
module riscv_core_id
  import riscv_core_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               if_id_valid,
  input  logic [31:0]        if_id_instr,
  input  logic [31:0]        if_id_pc,
  output logic               id_if_ready,
  input  logic               ex_id_stall,
  input  logic               ex_id_flush,
  output logic               id_ex_valid,
  output logic [FUNCT_W-1:0] id_ex_funct,
  output logic               id_ex_mux1_cntl,
  output logic [31:0]        id_ex_pc,
  output logic               id_ex_mux2_cntl,
  output logic [31:0]        id_ex_immed,
  output logic [4:0]         id_ct_rs1,
  output logic [4:0]         id_ct_rs2,
  output logic [4:0]         id_ex_rd,
  output logic               id_ex_illegal
);

  id_dec_t     dec;
  id_dec_t     dec_d, dec_q;
  logic [31:0] pc_d, pc_q;
  logic        valid_d, valid_q;
  logic        accept, hold;

  riscv_core_id_dec u_dec (
    .instr (if_id_instr),
    .dec   (dec)
  );

  assign id_if_ready = !valid_q || !ex_id_stall;
  assign accept      = if_id_valid && id_if_ready;
  assign hold        = valid_q && ex_id_stall;

  // Next-state: flush beats hold beats accept; otherwise a bubble (stale fields kept).
  always_comb begin
    dec_d   = dec_q;
    pc_d    = pc_q;
    valid_d = 1'b0;
    if (ex_id_flush) begin
      dec_d.funct   = FUNCT_NOP;
      dec_d.illegal = 1'b0;
    end else if (hold) begin
      valid_d = 1'b1;
    end else if (accept) begin
      dec_d   = dec;
      pc_d    = if_id_pc;
      valid_d = 1'b1;
    end else begin
      dec_d.funct   = FUNCT_NOP;
      dec_d.illegal = 1'b0;
    end
  end

  // ID/EX register; reset clears everything immediately, including a stalled op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_q   <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      dec_q   <= dec_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign id_ex_valid     = valid_q;
  assign id_ex_funct     = dec_q.funct;
  assign id_ex_mux1_cntl = dec_q.mux1;
  assign id_ex_mux2_cntl = dec_q.mux2;
  assign id_ex_immed     = dec_q.immed;
  assign id_ex_pc        = pc_q;
  assign id_ct_rs1       = dec_q.rs1;
  assign id_ct_rs2       = dec_q.rs2;
  assign id_ex_rd        = dec_q.rd;
  assign id_ex_illegal   = dec_q.illegal;

endmodule

// File: tb/tb_riscv_core_id.sv
// Directed bench for riscv_core_id: decode vectors, stall/flush and async reset.
module tb_riscv_core_id;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_id_valid = 1'b0;
  logic [31:0] if_id_instr = '0;
  logic [31:0] if_id_pc = '0;
  logic        id_if_ready;
  logic        ex_id_stall = 1'b0;
  logic        ex_id_flush = 1'b0;
  logic        id_ex_valid;
  logic [9:0]  id_ex_funct;
  logic        id_ex_mux1_cntl;
  logic [31:0] id_ex_pc;
  logic        id_ex_mux2_cntl;
  logic [31:0] id_ex_immed;
  logic [4:0]  id_ct_rs1, id_ct_rs2, id_ex_rd;
  logic        id_ex_illegal;

  int n_pass = 0;
  int n_total = 0;

  riscv_core_id dut (
    .clk             (clk),
    .rst             (rst),
    .if_id_valid     (if_id_valid),
    .if_id_instr     (if_id_instr),
    .if_id_pc        (if_id_pc),
    .id_if_ready     (id_if_ready),
    .ex_id_stall     (ex_id_stall),
    .ex_id_flush     (ex_id_flush),
    .id_ex_valid     (id_ex_valid),
    .id_ex_funct     (id_ex_funct),
    .id_ex_mux1_cntl (id_ex_mux1_cntl),
    .id_ex_pc        (id_ex_pc),
    .id_ex_mux2_cntl (id_ex_mux2_cntl),
    .id_ex_immed     (id_ex_immed),
    .id_ct_rs1       (id_ct_rs1),
    .id_ct_rs2       (id_ct_rs2),
    .id_ex_rd        (id_ex_rd),
    .id_ex_illegal   (id_ex_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance one clock and settle 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] instr, input logic [31:0] pc);
    if_id_valid = 1'b1;
    if_id_instr = instr;
    if_id_pc    = pc;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_valid", {31'd0, id_ex_valid}, 32'd0);
    chk("rst_funct", {22'd0, id_ex_funct}, 32'd0);
    chk("rst_ready", {31'd0, id_if_ready}, 32'd1);
    chk("rst_immed", id_ex_immed, 32'd0);
    chk("rst_pc", id_ex_pc, 32'd0);
    tick();
    tick();

    // ADDI x1,x2,-1 accepted on first edge after reset release
    rst = 1'b0;
    beat(32'hFFF10093, 32'h0000_0040);
    tick();
    chk("addi_valid", {31'd0, id_ex_valid}, 32'd1);
    chk("addi_funct", {22'd0, id_ex_funct}, 32'h001);
    chk("addi_mux1", {31'd0, id_ex_mux1_cntl}, 32'd0);
    chk("addi_mux2", {31'd0, id_ex_mux2_cntl}, 32'd1);
    chk("addi_immed", id_ex_immed, 32'hFFFF_FFFF);
    chk("addi_rs1", {27'd0, id_ct_rs1}, 32'd2);
    chk("addi_rd", {27'd0, id_ex_rd}, 32'd1);
    chk("addi_pc", id_ex_pc, 32'h40);

    // SUB x3,x1,x2
    beat(32'h402081B3, 32'h44);
    tick();
    chk("sub_funct", {22'd0, id_ex_funct}, 32'h002);
    chk("sub_mux1", {31'd0, id_ex_mux1_cntl}, 32'd0);
    chk("sub_mux2", {31'd0, id_ex_mux2_cntl}, 32'd0);
    chk("sub_immed", id_ex_immed, 32'd0);
    chk("sub_rs1", {27'd0, id_ct_rs1}, 32'd1);
    chk("sub_rs2", {27'd0, id_ct_rs2}, 32'd2);
    chk("sub_rd", {27'd0, id_ex_rd}, 32'd3);

    // AUIPC x5
    beat(32'h12345297, 32'h100);
    tick();
    chk("auipc_funct", {22'd0, id_ex_funct}, 32'h001);
    chk("auipc_mux1", {31'd0, id_ex_mux1_cntl}, 32'd1);
    chk("auipc_mux2", {31'd0, id_ex_mux2_cntl}, 32'd1);
    chk("auipc_immed", id_ex_immed, 32'h1234_5000);
    chk("auipc_pc", id_ex_pc, 32'h100);
    chk("auipc_rd", {27'd0, id_ex_rd}, 32'd5);

    // LUI x1,0xABCDE: rs1 field is nonzero in the word but forced to 0
    beat(32'hABCDE0B7, 32'h104);
    tick();
    chk("lui_funct", {22'd0, id_ex_funct}, 32'h001);
    chk("lui_mux1", {31'd0, id_ex_mux1_cntl}, 32'd0);
    chk("lui_mux2", {31'd0, id_ex_mux2_cntl}, 32'd1);
    chk("lui_immed", id_ex_immed, 32'hABCD_E000);
    chk("lui_rs1", {27'd0, id_ct_rs1}, 32'd0);
    chk("lui_rd", {27'd0, id_ex_rd}, 32'd1);

    // SRAI x1,x1,3
    beat(32'h4030D093, 32'h108);
    tick();
    chk("srai_funct", {22'd0, id_ex_funct}, 32'h200);
    chk("srai_immed", id_ex_immed, 32'h0000_0003);
    chk("srai_illegal", {31'd0, id_ex_illegal}, 32'd0);

    // All-zero word is illegal
    beat(32'h0000_0000, 32'h10C);
    tick();
    chk("zero_valid", {31'd0, id_ex_valid}, 32'd1);
    chk("zero_illegal", {31'd0, id_ex_illegal}, 32'd1);
    chk("zero_funct", {22'd0, id_ex_funct}, 32'd0);
    chk("zero_rd", {27'd0, id_ex_rd}, 32'd0);

    // OP with funct7=0100000, f3=010 is illegal; rd field (1) squashed
    beat(32'h400020B3, 32'h110);
    tick();
    chk("badf7_illegal", {31'd0, id_ex_illegal}, 32'd1);
    chk("badf7_rd", {27'd0, id_ex_rd}, 32'd0);

    // SLLI with funct7=0100000 is illegal
    beat(32'h40309093, 32'h114);
    tick();
    chk("badslli_illegal", {31'd0, id_ex_illegal}, 32'd1);
    chk("badslli_funct", {22'd0, id_ex_funct}, 32'd0);

    // OR x3,x1,x2
    beat(32'h0020E1B3, 32'h118);
    tick();
    chk("or_funct", {22'd0, id_ex_funct}, 32'h004);
    chk("or_illegal", {31'd0, id_ex_illegal}, 32'd0);

    // SLTIU x1,x2,5
    beat(32'h00513093, 32'h11C);
    tick();
    chk("sltiu_funct", {22'd0, id_ex_funct}, 32'h040);
    chk("sltiu_immed", id_ex_immed, 32'd5);
    chk("sltiu_mux2", {31'd0, id_ex_mux2_cntl}, 32'd1);

    // No beat -> bubble
    if_id_valid = 1'b0;
    tick();
    chk("bubble_valid", {31'd0, id_ex_valid}, 32'd0);
    chk("bubble_funct", {22'd0, id_ex_funct}, 32'd0);

    // Stall for 3 cycles with ADDI held, SUB waiting on input
    beat(32'hFFF10093, 32'h200);
    tick();
    ex_id_stall = 1'b1;
    beat(32'h402081B3, 32'h204);
    #1;
    chk("stall_ready", {31'd0, id_if_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", {31'd0, id_ex_valid}, 32'd1);
      chk("stall_funct", {22'd0, id_ex_funct}, 32'h001);
      chk("stall_immed", id_ex_immed, 32'hFFFF_FFFF);
      chk("stall_rd", {27'd0, id_ex_rd}, 32'd1);
      chk("stall_pc", id_ex_pc, 32'h200);
      chk("stall_ready_hold", {31'd0, id_if_ready}, 32'd0);
    end

    // Stall + flush: held op killed, incoming SUB dropped
    ex_id_flush = 1'b1;
    tick();
    chk("flush_valid", {31'd0, id_ex_valid}, 32'd0);
    chk("flush_funct", {22'd0, id_ex_funct}, 32'd0);
    chk("flush_illegal", {31'd0, id_ex_illegal}, 32'd0);
    ex_id_flush = 1'b0;
    ex_id_stall = 1'b0;
    if_id_valid = 1'b0;
    tick();
    chk("post_flush_valid", {31'd0, id_ex_valid}, 32'd0);

    // Flush while idle: beat consumed (ready=1) and discarded
    beat(32'h402081B3, 32'h208);
    ex_id_flush = 1'b1;
    #1;
    chk("flush_idle_ready", {31'd0, id_if_ready}, 32'd1);
    tick();
    chk("flush_idle_valid", {31'd0, id_ex_valid}, 32'd0);
    chk("flush_idle_funct", {22'd0, id_ex_funct}, 32'd0);
    ex_id_flush = 1'b0;
    if_id_valid = 1'b0;
    tick();
    chk("flush_idle_after", {31'd0, id_ex_valid}, 32'd0);

    // Async reset mid-stall
    beat(32'h12345297, 32'h300);
    tick();
    ex_id_stall = 1'b1;
    if_id_valid = 1'b0;
    tick();
    chk("pre_rst_valid", {31'd0, id_ex_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, id_ex_valid}, 32'd0);
    chk("arst_funct", {22'd0, id_ex_funct}, 32'd0);
    chk("arst_immed", id_ex_immed, 32'd0);
    chk("arst_pc", id_ex_pc, 32'd0);
    chk("arst_mux1", {31'd0, id_ex_mux1_cntl}, 32'd0);
    chk("arst_mux2", {31'd0, id_ex_mux2_cntl}, 32'd0);
    chk("arst_rd", {27'd0, id_ex_rd}, 32'd0);
    chk("arst_ready", {31'd0, id_if_ready}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/riscv_core_id.md
RISCV_CORE_ID -- requirements
Module: riscv_core_id

Interface
REQ-001 clk  in  1  sole clock; all state on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 if_id_valid  in  1  fetch presents an instruction this cycle.
REQ-004 if_id_instr  in  32  RV32 instruction word.
REQ-005 if_id_pc  in  32  PC of if_id_instr.
REQ-006 id_if_ready  out  1  decode accepts the fetch beat this cycle.
REQ-007 ex_id_stall  in  1  EX cannot take a new op; hold the output register.
REQ-008 ex_id_flush  in  1  kill the held op and the incoming beat.
REQ-009 id_ex_valid  out  1  output register holds a live op.
REQ-010 id_ex_funct  out  10  one-hot ALU op: ADD b0, SUB b1, OR b2, XOR b3, AND b4, SLT b5, SLTU b6, SLL b7, SRL b8, SRA b9; all-zero = NOP.
REQ-011 id_ex_mux1_cntl  out  1  1 = op1 is id_ex_pc, 0 = register rs1.
REQ-012 id_ex_pc  out  32  registered PC.
REQ-013 id_ex_mux2_cntl  out  1  1 = op2 is id_ex_immed, 0 = register rs2.
REQ-014 id_ex_immed  out  32  decoded immediate.
REQ-015 id_ct_rs1, id_ct_rs2  out  5 each  registered source register indices for operand fetch.
REQ-016 id_ex_rd  out  5  registered destination index.
REQ-017 id_ex_illegal  out  1  registered op is unsupported or malformed.

Function
REQ-018 A fetch beat is accepted when if_id_valid && id_if_ready; id_if_ready = !id_ex_valid || !ex_id_stall.
REQ-019 Latency is 1 cycle: an accepted beat appears on the id_ex_* outputs at the next rising edge.
REQ-020 While id_ex_valid && ex_id_stall && !ex_id_flush, all id_ex_*/id_ct_* outputs hold their values.
REQ-021 ex_id_flush has priority over stall and accept: next cycle id_ex_valid=0, funct=0, illegal=0; a beat arriving in the flush cycle is consumed (ready follows REQ-018) and discarded.
REQ-022 When no beat is accepted and the register is not held, next cycle id_ex_valid=0, funct=0 (bubble); the other fields may keep stale values.
REQ-023 OP (0110011), funct7=0000000: f3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
REQ-024 OP, funct7=0100000: f3 000 SUB, 101 SRA; any other f3 or funct7 is illegal.
REQ-025 OP decode: mux1=0, mux2=0, immed=0.
REQ-026 OP-IMM (0010011): f3 maps as in REQ-023 (no SUB), mux1=0, mux2=1, immed = sign-extended instr[31:20].
REQ-027 OP-IMM shifts: f3 001 requires instr[31:25]=0000000 (SLL); f3 101 requires 0000000 (SRL) or 0100000 (SRA); immed = zero-extended instr[24:20]; other funct7 values are illegal.
REQ-028 LUI (0110111): ADD, mux1=0, rs1 forced to 0, mux2=1, immed = {instr[31:12], 12'b0}.
REQ-029 AUIPC (0010111): ADD, mux1=1, mux2=1, immed as in LUI.
REQ-030 Any other opcode, or instr[1:0] != 11, is illegal.
REQ-031 An illegal op is registered with id_ex_valid=1, id_ex_illegal=1, funct=0, rd=0.
REQ-032 rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7] for every legal op (subject to REQ-028).

Reset
REQ-033 While rst=1, all outputs are 0 and id_if_ready=1; reset takes effect asynchronously, including mid-stall, and discards the held op.
REQ-034 The first accept is permitted on the first rising edge with rst=0.

Structure
REQ-035 A shared riscv_core_pkg holds the opcode constants, the FUNCT_*_OH one-hot constants (shared with EX) and the funct3/funct7 constants.
REQ-036 The combinational decode is a sub-module riscv_core_id_dec; riscv_core_id holds the handshake and the output register.

Verification
REQ-037 Accept 0xFFF10093 (ADDI x1,x2,-1) -> next cycle valid=1, funct=0x001, mux2=1, immed=0xFFFFFFFF, rs1=2, rd=1.
REQ-038 Accept 0x402081B3 (SUB x3,x1,x2) -> funct=0x002, mux1=0, mux2=0, rs1=1, rs2=2, rd=3.
REQ-039 Accept 0x12345297 (AUIPC x5) with pc=0x100 -> funct=0x001, mux1=1, mux2=1, immed=0x12345000, id_ex_pc=0x100.
REQ-040 Accept 0x4030D093 (SRAI x1,x1,3) -> funct=0x200, immed=0x00000003; 0x00000000 -> valid=1, illegal=1, funct=0.
REQ-041 Hold ex_id_stall=1 for 3 cycles with a valid op registered -> id_if_ready=0 and outputs stable; then assert stall and flush together -> next cycle valid=0 and the incoming beat is dropped.
REQ-042 Assert rst mid-stall -> all outputs 0 without waiting for a clock edge, id_if_ready=1.
